// File: rtl/mem_reader_pkg.sv
// Shared definitions for the memory, loader and reader blocks: size defaults
// and the reader FSM state encoding.
package mem_reader_pkg;

    localparam int MEM_SIZE_BYTES_DEF   = 4096;
    localparam int DATA_WIDTH_BYTES_DEF = 4;
    localparam int ADDR_WIDTH_DEF       = $clog2(MEM_SIZE_BYTES_DEF);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        STREAM  = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/mem_reader.sv
// Reads word_count words from a one-cycle-latency memory and streams them out
// byte by byte, lane 0 first. Optional running checksum: MEM_READER_CHECKSUM_EN.
module mem_reader
    import mem_reader_pkg::*;
#(
    parameter int MEM_SIZE_BYTES   = MEM_SIZE_BYTES_DEF,
    parameter int DATA_WIDTH_BYTES = DATA_WIDTH_BYTES_DEF,
    parameter int ADDR_WIDTH       = $clog2(MEM_SIZE_BYTES)
) (
    input  logic                          clk,
    input  logic                          rst_bar,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [ADDR_WIDTH:0]           word_count,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [DATA_WIDTH_BYTES-1:0]   w_bar,
    input  logic [DATA_WIDTH_BYTES*8-1:0] data_r,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
`ifdef MEM_READER_CHECKSUM_EN
    output logic [31:0]                   checksum,
`endif
    output logic                          done
);

    localparam int LANE_W = (DATA_WIDTH_BYTES > 1) ? $clog2(DATA_WIDTH_BYTES) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_WIDTH_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] WRAP_MASK  = ADDR_WIDTH'(MEM_SIZE_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(DATA_WIDTH_BYTES);
    localparam logic [LANE_W-1:0]     LAST_LANE  = LANE_W'(DATA_WIDTH_BYTES - 1);
    localparam logic [LANE_W-1:0]     LANE_ONE   = LANE_W'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE    = (ADDR_WIDTH + 1)'(1);

    state_e                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic [ADDR_WIDTH:0]           rem_q, rem_d;
    logic [LANE_W-1:0]             lane_q, lane_d;
    logic [DATA_WIDTH_BYTES*8-1:0] buf_q, buf_d;
    logic [7:0]                    out_byte_q, out_byte_d;
    logic                          out_valid_q, out_valid_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [31:0]                   cks_q, cks_d;

    // Next-state and next-output logic; outputs are derived from state_d so they register cleanly.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        lane_d     = lane_q;
        buf_d      = buf_q;
        out_byte_d = out_byte_q;
        cks_d      = cks_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cks_d = 32'h0000_0000;
                    if (word_count != '0) begin
                        addr_d  = base_addr & ALIGN_MASK;
                        rem_d   = word_count;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                buf_d      = data_r;
                lane_d     = '0;
                out_byte_d = data_r[7:0];
                state_d    = STREAM;
            end
            STREAM: begin
                // out_valid is high for the whole of STREAM, so out_ready alone is the handshake.
                if (out_ready) begin
                    cks_d = cks_q + {24'h00_0000, out_byte_q};
                    if (lane_q == LAST_LANE) begin
                        rem_d = rem_q - REM_ONE;
                        if (rem_q > REM_ONE) begin
                            addr_d  = (addr_q + ADDR_STEP) & WRAP_MASK;
                            state_d = ISSUE;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        lane_d     = lane_q + LANE_ONE;
                        out_byte_d = buf_q[8*int'(lane_d) +: 8];
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == STREAM);
        done_d      = (state_d == DONE);
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            lane_q      <= '0;
            buf_q       <= '0;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cks_q       <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cks_q       <= cks_d;
        end
    end

    assign addr      = addr_q;
    assign w_bar     = {DATA_WIDTH_BYTES{1'b1}};
    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef MEM_READER_CHECKSUM_EN
    assign checksum = cks_q;
`else
    logic unused_cks_s;
    assign unused_cks_s = ^cks_q;
`endif

endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader with a one-cycle-latency byte memory model.
module tb_mem_reader;
    import mem_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_bar = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = 12'd0;
    logic [12:0] word_count = 13'd0;
    logic [11:0] addr;
    logic [3:0]  w_bar;
    logic [31:0] data_r = 32'h0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
`ifdef MEM_READER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [7:0] mem [0:4095];
    logic [7:0] exp_q [$];
    int n_total = 0;
    int n_bad   = 0;

    mem_reader dut (
        .clk(clk), .rst_bar(rst_bar), .start(start), .base_addr(base_addr),
        .word_count(word_count), .addr(addr), .w_bar(w_bar), .data_r(data_r),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy),
`ifdef MEM_READER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    // Memory model: data_r reflects the address seen at the previous rising edge.
    always @(posedge clk) begin
        data_r <= {mem[12'(addr + 12'd3)], mem[12'(addr + 12'd2)],
                   mem[12'(addr + 12'd1)], mem[addr]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [11:0] b, input logic [12:0] n);
        @(negedge clk);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Collects nbytes accepted bytes against exp_q; optionally waits for the done pulse.
    task automatic stream_check(input int nbytes, input bit toggle, input bit wait_done,
                                input string tag, output int cyc);
        int got = 0;
        int dones = 0;
        bit stalled = 1'b0;
        logic [7:0] held = 8'h00;
        cyc = 0;
        while (got < nbytes && cyc < 400) begin
            @(negedge clk);
            cyc++;
            out_ready = toggle ? ~out_ready : 1'b1;
            if (done) dones++;
            if (stalled) begin
                chk({tag, "_hold_v"}, {31'd0, out_valid}, 32'd1);
                chk({tag, "_hold_b"}, {24'd0, out_byte}, {24'd0, held});
            end
            if (out_valid) begin
                if (out_ready) begin
                    chk($sformatf("%s_b%0d", tag, got), {24'd0, out_byte}, {24'd0, exp_q[got]});
                    got++;
                    stalled = 1'b0;
                end else begin
                    held    = out_byte;
                    stalled = 1'b1;
                end
            end
        end
        chk({tag, "_count"}, got, nbytes);
        if (wait_done) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done) dones++;
            end
            chk({tag, "_dones"}, dones, 32'd1);
            chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int cyc;
        int dones;
        logic [11:0] prev_addr;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);

        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_addr",  {20'd0, addr}, 32'd0);
        chk("rst_byte",  {24'd0, out_byte}, 32'd0);
        chk("rst_wbar",  {28'd0, w_bar}, 32'hF);
        @(negedge clk);
        rst_bar = 1'b1;

        // Four words from base 0, consumer always ready.
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        pulse_start(12'd0, 13'd4);
        stream_check(16, 1'b0, 1'b1, "seq", cyc);
        chk("seq_cycles", cyc, 32'd23);
`ifdef MEM_READER_CHECKSUM_EN
        chk("seq_cksum", checksum, 32'h0000_0078);
`endif

        // Zero-count request: done one cycle later, no data, no address change.
        prev_addr = addr;
        @(negedge clk);
        base_addr  = 12'd100;
        word_count = 13'd0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_valid", {31'd0, out_valid}, 32'd0);
        chk("zero_addr", {20'd0, addr}, {20'd0, prev_addr});
        @(negedge clk);
        chk("zero_done_off", {31'd0, done}, 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_valid2", {31'd0, out_valid}, 32'd0);

        // Two words with out_ready toggling every cycle.
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        out_ready = 1'b0;
        pulse_start(12'd0, 13'd2);
        stream_check(8, 1'b1, 1'b1, "tog", cyc);

        // Reset in the middle of word 2 of 4, then a fresh one-word read.
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        pulse_start(12'd0, 13'd4);
        stream_check(6, 1'b0, 1'b0, "pre", cyc);
        @(negedge clk);
        rst_bar = 1'b0;
        #1;
        chk("mid_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_busy",  {31'd0, busy}, 32'd0);
        chk("mid_addr",  {20'd0, addr}, 32'd0);
        chk("mid_byte",  {24'd0, out_byte}, 32'd0);
        chk("mid_done",  {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_bar = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("mid_nodone", dones, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
        pulse_start(12'd0, 13'd1);
        stream_check(4, 1'b0, 1'b1, "fresh", cyc);
`ifdef MEM_READER_CHECKSUM_EN
        chk("fresh_cksum", checksum, 32'h0000_0006);
`endif

        // Wrap from the top of memory; unaligned base low bits are ignored.
        mem[4092] = 8'hAA; mem[4093] = 8'hBB; mem[4094] = 8'hCC; mem[4095] = 8'hDD;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        exp_q.delete();
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
        exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        pulse_start(12'd4095, 13'd2);
        stream_check(8, 1'b0, 1'b1, "wrap", cyc);
        chk("wrap_addr", {20'd0, addr}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 Parameter MEM_SIZE_BYTES, default 4096, memory size in bytes; SHALL be a power of 2.
REQ-002 Parameter DATA_WIDTH_BYTES, default 4, bytes per memory word / byte lanes.
REQ-003 Parameter ADDR_WIDTH, default $clog2(MEM_SIZE_BYTES), byte-address width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_bar  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a readout; sampled in IDLE only.
REQ-007 base_addr  input  ADDR_WIDTH  first byte address, word aligned (low 2 bits ignored).
REQ-008 word_count  input  ADDR_WIDTH+1  number of words to read; 0 allowed.
REQ-009 addr  output  ADDR_WIDTH  memory byte address, word aligned.
REQ-010 w_bar  output  [DATA_WIDTH_BYTES] x 1  per-lane active-low write enables to memory; constant 1 (reads only).
REQ-011 data_r  input  [DATA_WIDTH_BYTES] x 8  memory read data, lane 0 = lowest byte address.
REQ-012 out_byte  output  8  streamed byte.
REQ-013 out_valid  output  1  out_byte valid.
REQ-014 out_ready  input  1  consumer accepts out_byte when out_valid && out_ready.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse after last byte accepted or after zero-count request.

Function
REQ-017 Memory read latency SHALL be one cycle: data_r reflects addr presented on the previous posedge.
REQ-018 FSM states SHALL be IDLE, ISSUE, CAPTURE, STREAM, DONE.
REQ-019 IDLE: start && word_count!=0 -> latch base_addr/word_count, drive addr, go ISSUE; start && word_count==0 -> DONE.
REQ-020 ISSUE -> CAPTURE unconditionally (latency cycle); CAPTURE latches all DATA_WIDTH_BYTES lanes of data_r into a word buffer, -> STREAM.
REQ-021 STREAM SHALL emit buffered bytes lane 0 first, lane DATA_WIDTH_BYTES-1 last, one byte per accepted handshake.
REQ-022 out_byte and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 After last lane accepted: remaining words >0 -> addr += DATA_WIDTH_BYTES, -> ISSUE; else -> DONE.
REQ-024 Address increment SHALL wrap modulo MEM_SIZE_BYTES (4092 -> 0 for defaults).
REQ-025 DONE asserts done for exactly one cycle, -> IDLE.
REQ-026 start while busy SHALL be ignored; inputs not re-sampled mid-operation.
REQ-027 out_valid SHALL be low in every state except STREAM.
REQ-028 Minimum throughput: 2 + DATA_WIDTH_BYTES cycles per word with out_ready held high.

Reset
REQ-029 rst_bar low SHALL immediately force IDLE, addr=0, out_byte=0, out_valid=0, busy=0, done=0, word buffer=0, w_bar all 1s.
REQ-030 Reset mid-operation SHALL abandon the transfer with no done pulse; next start begins fresh.

Configuration
REQ-031 Macro MEM_READER_CHECKSUM_EN defined: add output checksum (32 bits), cleared on accepted start, adds each accepted out_byte zero-extended, wraps mod 2^32, holds after done, reset to 0.
REQ-032 Macro undefined: no checksum port or logic; all other behaviour identical.

Structure
REQ-033 MEM_SIZE_BYTES, DATA_WIDTH_BYTES, ADDR_WIDTH defaults and the FSM state enum typedef SHALL live in a shared package used by memory, loader and reader.
REQ-034 No sub-module; byte-lane serializer stays inline.

Verification
REQ-035 Memory preloaded 0x00..0x0F at bytes 0..15, base 0, count 4, out_ready=1 -> bytes 00,01,...,0F in order, one done pulse, busy low after.
REQ-036 count 0 start -> done pulse 1 cycle after start, out_valid never high, no addr change.
REQ-037 base 4092, count 2, bytes at 4092..4095 = AA BB CC DD, 0..3 = 11 22 33 44 -> AA BB CC DD 11 22 33 44 (wrap).
REQ-038 out_ready toggled 0/1 every cycle on 2-word read -> every byte emitted once, held stable while stalled, no loss or duplication.
REQ-039 rst_bar low during STREAM of word 2 of 4 -> outputs at reset values same cycle, no done; subsequent start base 0 count 1 -> 00 01 02 03.
REQ-040 With MEM_READER_CHECKSUM_EN, REQ-035 stimulus -> checksum 0x00000078 after done.
